// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: IDLE/DECODE/EXEC/MEM/WB sequencer that
// latches an instruction on an inst_valid/inst_ready handshake and drives the
// datapath strobes for add/sub/and/or/slt, lw, sw, beq, addi and j.
// Optional build macro: MIPS_MC_CTRL_PERF_EN adds the retired_cnt and
// stall_cnt performance counters (absent in the default build).

package mips;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } rtype_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } itype_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] addr;
    } jtype_t;

    typedef union packed {
        rtype_t r;
        itype_t i;
        jtype_t j;
    } mipsinst;

endpackage

module mips_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_valid,
    input  mips::mipsinst inst,
    output logic          inst_ready,
    input  logic          mem_ready,
    output logic [2:0]    state,
    output logic          ir_we,
    output logic          pc_we,
    output logic          reg_we,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          alu_src_imm,
    output logic          reg_dst_rd,
    output logic          branch,
    output logic          jump,
    output logic          illegal,
    output logic [2:0]    alu_op
`ifdef MIPS_MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    state_t        state_q;
    state_t        state_d;
    mips::mipsinst inst_q;
    mips::mipsinst inst_d;

    logic       handshake;
    logic       isR;
    logic       isLw;
    logic       isSw;
    logic       isBeq;
    logic       isAddi;
    logic       isJ;
    logic       isLegal;
    logic [2:0] rFuncOp;

    // Register fields are consumed by the datapath, not by the controller.
    logic unusedFields;
    assign unusedFields = ^inst_q[25:6];

    // Accept only in IDLE and never while reset is held.
    assign handshake = inst_valid & ~rst & (state_q == IDLE);
    assign inst_d    = handshake ? inst : inst_q;
    assign state     = state_q;

    // Classify the latched instruction; the live inst port never reaches here.
    always_comb begin
        isR     = 1'b0;
        isLw    = 1'b0;
        isSw    = 1'b0;
        isBeq   = 1'b0;
        isAddi  = 1'b0;
        isJ     = 1'b0;
        rFuncOp = ALU_ADD;
        case (inst_q.r.opcode)
            6'b000000: begin
                case (inst_q.r.func)
                    6'b100000: begin isR = 1'b1; rFuncOp = ALU_ADD; end
                    6'b100010: begin isR = 1'b1; rFuncOp = ALU_SUB; end
                    6'b100100: begin isR = 1'b1; rFuncOp = ALU_AND; end
                    6'b100101: begin isR = 1'b1; rFuncOp = ALU_OR;  end
                    6'b101010: begin isR = 1'b1; rFuncOp = ALU_SLT; end
                    default:   isR = 1'b0;
                endcase
            end
            6'b100011: isLw   = 1'b1;
            6'b101011: isSw   = 1'b1;
            6'b000100: isBeq  = 1'b1;
            6'b001000: isAddi = 1'b1;
            6'b000010: isJ    = 1'b1;
            default:   isR    = 1'b0;
        endcase
        isLegal = isR | isLw | isSw | isBeq | isAddi | isJ;
    end

    // Next state and all datapath strobes, decoded from state and latched word.
    always_comb begin
        state_d     = state_q;
        inst_ready  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        alu_src_imm = 1'b0;
        reg_dst_rd  = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        illegal     = 1'b0;
        alu_op      = ALU_ADD;
        case (state_q)
            IDLE: begin
                inst_ready = ~rst;
                ir_we      = handshake;
                if (handshake) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!isLegal) begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end else if (isJ) begin
                    jump    = 1'b1;
                    pc_we   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (isBeq) begin
                    branch  = 1'b1;
                    alu_op  = ALU_SUB;
                    pc_we   = 1'b1;
                    state_d = IDLE;
                end else if (isR) begin
                    alu_op  = rFuncOp;
                    state_d = WB;
                end else begin
                    // addi result or lw/sw effective address: rs + imm
                    alu_src_imm = 1'b1;
                    alu_op      = ALU_ADD;
                    state_d     = isAddi ? WB : MEM;
                end
            end
            MEM: begin
                mem_rd = isLw;
                mem_wr = isSw;
                if (mem_ready) begin
                    pc_we   = isSw;
                    state_d = isLw ? WB : IDLE;
                end
            end
            WB: begin
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                reg_dst_rd  = isR;
                alu_src_imm = isAddi;
                alu_op      = isR ? rFuncOp : ALU_ADD;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and instruction registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

`ifdef MIPS_MC_CTRL_PERF_EN
    logic [CNT_W-1:0] retiredCnt_q;
    logic [CNT_W-1:0] stallCnt_q;

    assign retired_cnt = retiredCnt_q;
    assign stall_cnt   = stallCnt_q;

    // Retired instructions count PC updates; stalls count unfinished MEM cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retiredCnt_q <= '0;
            stallCnt_q   <= '0;
        end else begin
            if (pc_we) begin
                retiredCnt_q <= retiredCnt_q + CNT_W'(1);
            end
            if ((state_q == MEM) && !mem_ready) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] unusedCntWidth;
    assign unusedCntWidth = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized self-checking bench for mips_mc_ctrl. Each instruction is turned
// into a plan of expected per-cycle outputs derived from its instruction class;
// the DUT is stepped through the plan while the inst port and unrelated inputs
// are scrambled. Counter checks are compiled in with MIPS_MC_CTRL_PERF_EN.

module tb_mips_mc_ctrl;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic       irWe;
        logic       pcWe;
        logic       regWe;
        logic       memRd;
        logic       memWr;
        logic       imm;
        logic       dst;
        logic       br;
        logic       jmp;
        logic       ill;
        logic [2:0] op;
        logic       rdy;
        logic [2:0] st;
    } outs_t;

    typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_ILL} kind_t;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        mem_ready;
    logic [2:0]  state;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        alu_src_imm;
    logic        reg_dst_rd;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [2:0]  alu_op;
`ifdef MIPS_MC_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] expRetired = 0;
    logic [31:0] expStall   = 0;

    outs_t plan[$];
    int    planDrive[$];

    mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_ready  (inst_ready),
        .mem_ready   (mem_ready),
        .state       (state),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .reg_we      (reg_we),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .alu_src_imm (alu_src_imm),
        .reg_dst_rd  (reg_dst_rd),
        .branch      (branch),
        .jump        (jump),
        .illegal     (illegal),
        .alu_op      (alu_op)
`ifdef MIPS_MC_CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic memReady);
        inst_valid = valid;
        inst       = word;
        mem_ready  = memReady;
    endtask

    function automatic outs_t observe();
        return {ir_we, pc_we, reg_we, mem_rd, mem_wr, alu_src_imm, reg_dst_rd,
                branch, jump, illegal, alu_op, inst_ready, state};
    endfunction

    function automatic logic [2:0] funcOp(input logic [5:0] f);
        case (f)
            6'b100010: return 3'd1;
            6'b100100: return 3'd2;
            6'b100101: return 3'd3;
            6'b101010: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic kind_t classify(input logic [31:0] w);
        case (w[31:26])
            6'b000000: begin
                case (w[5:0])
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return K_R;
                    default: return K_ILL;
                endcase
            end
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] randInst();
        logic [5:0]  fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0]  bad [5] = '{6'b111111, 6'b001101, 6'b100000, 6'b000101, 6'b000000};
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: begin w[31:26] = 6'b000000; w[5:0] = fns[$urandom_range(0, 4)]; end
            1: w[31:26] = 6'b100011;
            2: w[31:26] = 6'b101011;
            3: w[31:26] = 6'b000100;
            4: w[31:26] = 6'b001000;
            5: w[31:26] = 6'b000010;
            default: begin
                w[31:26] = bad[$urandom_range(0, 4)];
                if (w[31:26] == 6'b000000) begin
                    w[5:0] = 6'b000011;
                end
            end
        endcase
        return w;
    endfunction

    task automatic addStep(input outs_t s, input int drive);
        plan.push_back(s);
        planDrive.push_back(drive);
    endtask

    // Expected cycle-by-cycle outputs after the handshake, from the class table
    task automatic buildPlan(input kind_t kind, input logic [31:0] w, input int stalls);
        outs_t s;
        plan.delete();
        planDrive.delete();
        s = '0;
        s.st = 3'd1;
        if (kind == K_ILL) begin
            s.ill = 1'b1;
            addStep(s, -1);
            return;
        end
        if (kind == K_J) begin
            s.jmp = 1'b1;
        end
        addStep(s, -1);
        s = '0;
        s.st = 3'd2;
        case (kind)
            K_BEQ: begin
                s.br = 1'b1;
                s.op = 3'd1;
                addStep(s, -1);
            end
            K_R: begin
                s.op = funcOp(w[5:0]);
                addStep(s, -1);
                s.st = 3'd4; s.regWe = 1'b1; s.dst = 1'b1;
                addStep(s, -1);
            end
            K_ADDI: begin
                s.imm = 1'b1;
                addStep(s, -1);
                s.st = 3'd4; s.regWe = 1'b1;
                addStep(s, -1);
            end
            K_LW, K_SW: begin
                s.imm = 1'b1;
                addStep(s, -1);
                s = '0;
                s.st = 3'd3;
                s.memRd = (kind == K_LW);
                s.memWr = (kind == K_SW);
                for (int i = 0; i <= stalls; i++) begin
                    addStep(s, (i == stalls) ? 1 : 0);
                end
                if (kind == K_LW) begin
                    s = '0;
                    s.st = 3'd4; s.regWe = 1'b1;
                    addStep(s, -1);
                end
            end
            default: begin end
        endcase
        s = plan.pop_back();
        s.pcWe = 1'b1;
        plan.push_back(s);
    endtask

    task automatic checkCounters(input string tag);
`ifdef MIPS_MC_CTRL_PERF_EN
        checkOutput({tag, " retired_cnt"}, retired_cnt, expRetired);
        checkOutput({tag, " stall_cnt"}, stall_cnt, expStall);
`else
        if (tag.len() < 0) begin
            $display("[TB] %s", tag);
        end
`endif
    endtask

    // One instruction: handshake cycle, then each planned cycle. A non-negative
    // abortStep asserts reset partway through that cycle instead.
    task automatic runInstr(input string name, input logic [31:0] w, input int stalls, input int abortStep);
        kind_t kind;
        outs_t e;
        kind = classify(w);
        buildPlan(kind, w, stalls);
        applyStimulus(1'b1, w, 1'($urandom_range(0, 1)));
        @(negedge clk);
        e = '0; e.irWe = 1'b1; e.rdy = 1'b1;
        checkOutput({name, " handshake"}, 32'(observe()), 32'(e));
        @(posedge clk); #1;
        for (int i = 0; i < plan.size(); i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom,
                          (planDrive[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(planDrive[i]));
            if (i == abortStep) begin
                #2;
                rst = 1'b1;
                #1;
                checkOutput({name, " async reset"}, 32'(observe()), 32'(0));
                expRetired = 0;
                expStall   = 0;
                @(posedge clk); #1;
                checkOutput({name, " held in reset"}, 32'(observe()), 32'(0));
                checkCounters({name, " reset"});
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            checkOutput($sformatf("%s step%0d", name, i), 32'(observe()), 32'(plan[i]));
            @(posedge clk); #1;
        end
        if (kind != K_ILL) begin
            expRetired = expRetired + 1;
        end
        if (kind == K_LW || kind == K_SW) begin
            expStall = expStall + 32'(stalls);
        end
        checkCounters(name);
    endtask

    initial begin
        outs_t e;
        logic [31:0] w;
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0022_1820, 1'b1);
        #2;
        @(negedge clk);
        checkOutput("reset outputs", 32'(observe()), 32'(0));
        checkCounters("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle with nothing offered
        applyStimulus(1'b0, 32'h0022_1820, 1'b0);
        @(negedge clk);
        e = '0; e.rdy = 1'b1;
        checkOutput("idle no valid", 32'(observe()), 32'(e));
        @(posedge clk); #1;

        runInstr("add", {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 0, -1);
        runInstr("lw", {6'b100011, 5'd4, 5'd5, 16'h0010}, 3, -1);
        runInstr("illegal", {6'b111111, 26'h2AB_CDEF}, 0, -1);
        runInstr("j", {6'b000010, 26'h000_0040}, 0, -1);
        runInstr("sw reset", {6'b101011, 5'd6, 5'd7, 16'hFFFC}, 5, 4);
        runInstr("beq", {6'b000100, 5'd1, 5'd2, 16'h0003}, 0, -1);
        runInstr("sw", {6'b101011, 5'd8, 5'd9, 16'h0004}, 1, -1);
        runInstr("addi", {6'b001000, 5'd3, 5'd3, 16'h8001}, 0, -1);

        for (int n = 0; n < 60; n++) begin
            w = randInst();
            runInstr($sformatf("rand%0d", n), w, $urandom_range(0, 4), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port inst_valid, input, 1, instruction offered.
REQ-005 SHALL have port inst, input, 32 (mips::mipsinst), instruction word, decoded through its r/i/j views.
REQ-006 SHALL have port inst_ready, output, 1, controller accepts inst this cycle.
REQ-007 SHALL have port mem_ready, input, 1, data memory completes the current access.
REQ-008 SHALL have port state, output, 3, current FSM state: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-009 SHALL have outputs ir_we, pc_we, reg_we, mem_rd, mem_wr, alu_src_imm, reg_dst_rd, branch, jump, illegal, each 1 bit, datapath strobes/selects.
REQ-010 SHALL have port alu_op, output, 3, ADD=0, SUB=1, AND=2, OR=3, SLT=4.
REQ-011 SHALL have ports retired_cnt and stall_cnt, output, CNT_W each, present only per REQ-029.

Function
REQ-012 SHALL assert inst_ready only in IDLE; handshake = inst_valid & inst_ready; ir_we pulses in that cycle and the FSM enters DECODE.
REQ-013 SHALL latch inst on handshake; later changes on inst SHALL NOT affect the operation in flight.
REQ-014 Decode SHALL cover: opcode 000000 with func 100000/100010/100100/100101/101010 (add/sub/and/or/slt), 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j; all else illegal.
REQ-015 R-type path SHALL be DECODE->EXEC->WB->IDLE; WB asserts reg_we and reg_dst_rd; alu_op from func.
REQ-016 addi SHALL be DECODE->EXEC->WB->IDLE with alu_src_imm=1 in EXEC and WB, reg_dst_rd=0, alu_op=ADD.
REQ-017 lw SHALL be DECODE->EXEC->MEM->WB->IDLE; mem_rd held high in MEM until mem_ready=1.
REQ-018 sw SHALL be DECODE->EXEC->MEM->IDLE; mem_wr held high in MEM until mem_ready=1.
REQ-019 beq SHALL be DECODE->EXEC->IDLE with branch=1 and alu_op=SUB in EXEC; jump SHALL be DECODE->IDLE with jump=1 in DECODE.
REQ-020 Illegal instruction SHALL return DECODE->IDLE with illegal pulsed for exactly that DECODE cycle; no other strobe asserted.
REQ-021 pc_we SHALL pulse one cycle on the last state of each legal instruction (the cycle whose next state is IDLE).
REQ-022 MEM with mem_ready=0 SHALL hold state and all outputs unchanged; mem_ready is ignored outside MEM.
REQ-023 All strobes SHALL be 0 in IDLE except inst_ready; outputs decode from state and latched instruction only.

Reset
REQ-024 rst=1 SHALL force state=IDLE immediately, regardless of the clock, including mid-MEM wait.
REQ-025 During reset all strobes, alu_op and illegal SHALL be 0; inst_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-026 The latched instruction SHALL reset to 0; counters SHALL reset to 0 when present.

Configuration
REQ-027 Macro MIPS_MC_CTRL_PERF_EN SHALL control the performance counters.
REQ-028 Without it, retired_cnt/stall_cnt ports and logic SHALL be absent; all other behaviour identical.
REQ-029 With it, retired_cnt SHALL increment on each pc_we pulse and stall_cnt on each MEM cycle with mem_ready=0; both wrap at 2^CNT_W-1 to 0.

Verification
REQ-030 Reset then add (func 100000), inst_valid=1 -> ir_we@c0, DECODE@c1, EXEC@c2, WB@c3 with reg_we=1, reg_dst_rd=1, pc_we=1, IDLE@c4.
REQ-031 lw with mem_ready low 3 MEM cycles -> mem_rd high 4 cycles, then WB reg_we=1; stall_cnt=3 with PERF_EN.
REQ-032 Opcode 111111 -> illegal=1 for one DECODE cycle, no pc_we, IDLE next; j -> jump=1, pc_we=1 in DECODE.
REQ-033 rst asserted mid-MEM of sw -> state=0 and mem_wr=0 immediately, no pc_we; next instruction runs normally.
REQ-034 Back-to-back beq, sw, addi with inst_valid always high -> each accepted only in IDLE, retired_cnt=3 at end; inst changes after handshake ignored.
